// File: rtl/qracc_sram_sequencer_if.sv
// Request/response handshake between the weight-loading controller and the column-bank
// SRAM sequencer.
interface qracc_sram_sequencer_if #(
    parameter int unsigned numRows = 128,
    parameter int unsigned numCols = 32
) ();
    localparam int unsigned AddrW = (numRows > 1) ? $clog2(numRows) : 1;

    logic               rq_valid_i;
    logic               rq_wr_i;
    logic [AddrW-1:0]   addr_i;
    logic [numCols-1:0] wr_data_i;
    logic               rq_ready_o;
    logic               rd_valid_o;
    logic [numCols-1:0] rd_data_o;

    modport master (
        output rq_valid_i, rq_wr_i, addr_i, wr_data_i,
        input  rq_ready_o, rd_valid_o, rd_data_o
    );

    modport slave (
        input  rq_valid_i, rq_wr_i, addr_i, wr_data_i,
        output rq_ready_o, rd_valid_o, rd_data_o
    );
endinterface

// File: rtl/qracc_sram_sequencer.sv
// SRAM access sequencer for one QRAcc column bank: turns single-row read/write requests
// into timed PCH -> WL -> (WRITE | SAEN) pulses and captures SA_OUT as read data.
// All analog-facing outputs are flops so the macro never sees combinational glitches.
module qracc_sram_sequencer #(
    parameter int unsigned numRows      = 128,
    parameter int unsigned numCols      = 32,
    parameter int unsigned PCH_CYCLES   = 1,
    parameter int unsigned WL_CYCLES    = 2,
    parameter int unsigned SENSE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   nrst,
    qracc_sram_sequencer_if.slave  bus,
    output logic [numRows-1:0]     WL,
    output logic                   PCH,
    output logic                   WRITE,
    output logic [numCols-1:0]     WR_DATA,
    output logic [numCols-1:0]     CSEL,
    output logic                   SAEN,
    input  logic [numCols-1:0]     SA_OUT
);
    localparam int unsigned AddrW = (numRows > 1) ? $clog2(numRows) : 1;
    localparam int unsigned CntW  = 16;

    typedef enum logic [1:0] {S_IDLE, S_PCH, S_WL, S_SENSE} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [AddrW-1:0]   addr_q, addr_d;
    logic               wr_q, wr_d;
    logic [numCols-1:0] data_q, data_d;
    logic [numCols-1:0] rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               ready_q, ready_d;
    logic [numRows-1:0] wl_q, wl_d;
    logic               pch_q, pch_d;
    logic               write_q, write_d;
    logic [numCols-1:0] wr_data_q, wr_data_d;
    logic [numCols-1:0] csel_q, csel_d;
    logic               saen_q, saen_d;
    logic               addr_in_range;

    // Rows beyond numRows exist in the address space when numRows is not a power of two.
    assign addr_in_range = (32'(addr_q) < numRows);

    // Next-state: phase sequencing with a down-counter loaded with length-1 on entry.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        data_d     = data_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.rq_valid_i && ready_q) begin
                    addr_d  = bus.addr_i;
                    wr_d    = bus.rq_wr_i;
                    data_d  = bus.wr_data_i;
                    cnt_d   = CntW'(PCH_CYCLES - 1);
                    state_d = S_PCH;
                end
            end
            S_PCH: begin
                if (cnt_q == '0) begin
                    cnt_d   = CntW'(WL_CYCLES - 1);
                    state_d = S_WL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WL: begin
                if (cnt_q == '0) begin
                    if (wr_q) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = CntW'(SENSE_CYCLES - 1);
                        state_d = S_SENSE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SENSE: begin
                if (cnt_q == '0) begin
                    rd_data_d  = addr_in_range ? SA_OUT : '0;
                    rd_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state and latched request; registered below.
    always_comb begin
        ready_d   = (state_d == S_IDLE);
        pch_d     = (state_d == S_PCH);
        saen_d    = (state_d == S_SENSE);
        write_d   = (state_d == S_WL) && wr_d;
        wr_data_d = write_d ? data_d : '0;
        csel_d    = (state_d != S_IDLE) ? '1 : '0;
        wl_d      = '0;
        if (state_d == S_WL) begin
            for (int unsigned r = 0; r < numRows; r++) begin
                if (addr_d == AddrW'(r)) wl_d[r] = 1'b1;
            end
        end
    end

    // Single state/output register bank; reset aborts any pulse immediately.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            data_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ready_q    <= 1'b0;
            wl_q       <= '0;
            pch_q      <= 1'b0;
            write_q    <= 1'b0;
            wr_data_q  <= '0;
            csel_q     <= '0;
            saen_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            data_q     <= data_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ready_q    <= ready_d;
            wl_q       <= wl_d;
            pch_q      <= pch_d;
            write_q    <= write_d;
            wr_data_q  <= wr_data_d;
            csel_q     <= csel_d;
            saen_q     <= saen_d;
        end
    end

    assign bus.rq_ready_o = ready_q;
    assign bus.rd_valid_o = rd_valid_q;
    assign bus.rd_data_o  = rd_data_q;
    assign WL             = wl_q;
    assign PCH            = pch_q;
    assign WRITE          = write_q;
    assign WR_DATA        = wr_data_q;
    assign CSEL           = csel_q;
    assign SAEN           = saen_q;
endmodule

// File: tb/tb_qracc_sram_sequencer.sv
// Bench for qracc_sram_sequencer: one default instance and one with stretched phases and
// a non-power-of-two row count. Expected waveforms come from the phase-length arithmetic.
module tb_qracc_sram_sequencer;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        sel = 1'b0;
    logic        valid = 1'b0;
    logic        wr_i = 1'b0;
    logic [6:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] sa_drv = '0;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    logic [31:0] rd_m [2];

    always #5 clk = ~clk;

    qracc_sram_sequencer_if #(.numRows(128), .numCols(32)) if1 ();
    qracc_sram_sequencer_if #(.numRows(100), .numCols(32)) if2 ();

    assign if1.rq_valid_i = valid & ~sel;
    assign if1.rq_wr_i    = wr_i;
    assign if1.addr_i     = addr;
    assign if1.wr_data_i  = wdata;
    assign if2.rq_valid_i = valid & sel;
    assign if2.rq_wr_i    = wr_i;
    assign if2.addr_i     = addr;
    assign if2.wr_data_i  = wdata;

    logic [127:0] wl1;
    logic [99:0]  wl2;
    logic         pch1, pch2, write1, write2, saen1, saen2;
    logic [31:0]  wrd1, wrd2, csel1, csel2;

    qracc_sram_sequencer dut1 (
        .clk(clk), .nrst(nrst), .bus(if1.slave), .WL(wl1), .PCH(pch1), .WRITE(write1),
        .WR_DATA(wrd1), .CSEL(csel1), .SAEN(saen1), .SA_OUT(sa_drv)
    );

    qracc_sram_sequencer #(
        .numRows(100), .numCols(32), .PCH_CYCLES(2), .WL_CYCLES(3), .SENSE_CYCLES(2)
    ) dut2 (
        .clk(clk), .nrst(nrst), .bus(if2.slave), .WL(wl2), .PCH(pch2), .WRITE(write2),
        .WR_DATA(wrd2), .CSEL(csel2), .SAEN(saen2), .SA_OUT(sa_drv)
    );

    // Observation mux over the selected instance.
    logic [127:0] wl_o;
    logic         pch_o, write_o, saen_o, rdy_o, rdv_o;
    logic [31:0]  wrd_o, csel_o, rdd_o;
    assign wl_o    = sel ? {28'b0, wl2} : wl1;
    assign pch_o   = sel ? pch2 : pch1;
    assign write_o = sel ? write2 : write1;
    assign saen_o  = sel ? saen2 : saen1;
    assign wrd_o   = sel ? wrd2 : wrd1;
    assign csel_o  = sel ? csel2 : csel1;
    assign rdy_o   = sel ? if2.rq_ready_o : if1.rq_ready_o;
    assign rdv_o   = sel ? if2.rd_valid_o : if1.rd_valid_o;
    assign rdd_o   = sel ? if2.rd_data_o : if1.rd_data_o;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request (caller sits at a negedge) and check every cycle of its timeline.
    task automatic run_op(input bit wr, input logic [6:0] a, input logic [31:0] d,
                          input bit hold);
        int unsigned p, w, s, nr, total;
        logic [31:0] sa;
        logic [127:0] wl_e;
        bit ok, pch_e, wl_on, saen_e, rdv_e, rdy_e, write_e;
        p  = sel ? 2 : 1;
        w  = sel ? 3 : 2;
        s  = sel ? 2 : 1;
        nr = sel ? 100 : 128;
        sa = $urandom;
        valid = 1'b1;
        wr_i  = wr;
        addr  = a;
        wdata = d;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rdy_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("ready_timeout", 128'(rdy_o), 128'd1);
            valid = 1'b0;
            return;
        end
        @(posedge clk);
        total = wr ? p + w + 1 : p + w + s + 1;
        for (int unsigned k = 1; k <= total; k++) begin
            @(negedge clk);
            if (!hold && k == 1) valid = 1'b0;
            pch_e   = (k <= p);
            wl_on   = (k > p) && (k <= p + w);
            saen_e  = !wr && (k > p + w) && (k <= p + w + s);
            rdv_e   = !wr && (k == total);
            rdy_e   = (k == total);
            write_e = wr && wl_on;
            wl_e    = '0;
            if (wl_on && a < nr) wl_e[a] = 1'b1;
            sa_drv = saen_e ? sa : $urandom;
            if (rdv_e) rd_m[sel] = (a < nr) ? sa : 32'd0;
            chk("pch", 128'(pch_o), 128'(pch_e));
            chk("wl", wl_o, wl_e);
            chk("write", 128'(write_o), 128'(write_e));
            chk("wr_data", 128'(wrd_o), write_e ? 128'(d) : 128'd0);
            chk("csel", 128'(csel_o), (k < total) ? 128'hFFFF_FFFF : 128'd0);
            chk("saen", 128'(saen_o), 128'(saen_e));
            chk("ready", 128'(rdy_o), 128'(rdy_e));
            chk("rd_valid", 128'(rdv_o), 128'(rdv_e));
            chk("rd_data", 128'(rdd_o), 128'(rd_m[sel]));
            chk("wl_onehot0", 128'($onehot0(wl_o)), 128'd1);
            chk("saen_overlap", 128'(saen_o & ((|wl_o) | pch_o)), 128'd0);
        end
    endtask

    initial begin
        rd_m[0] = '0;
        rd_m[1] = '0;
        #3;
        // Reset state of both instances.
        sel = 1'b0;
        chk("rst_ready", 128'(rdy_o), 128'd0);
        chk("rst_rd_data", 128'(rdd_o), 128'd0);
        chk("rst_wl_pch_saen", {wl_o[124:0], pch_o, saen_o, write_o}, 128'd0);
        sel = 1'b1;
        chk("rst_ready2", 128'(rdy_o), 128'd0);
        chk("rst_csel2", 128'(csel_o), 128'd0);
        sel = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;

        // Directed write and read on the default instance.
        run_op(1'b1, 7'd5, 32'hA5A5_A5A5, 1'b0);
        run_op(1'b0, 7'd5, 32'h0, 1'b0);
        // Valid held through a busy read, second request taken in the rd_valid cycle.
        run_op(1'b0, 7'($urandom_range(0, 127)), 32'h0, 1'b1);
        run_op(1'b0, 7'($urandom_range(0, 127)), 32'h0, 1'b1);
        run_op(1'b1, 7'($urandom_range(0, 127)), $urandom, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run_op(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), $urandom,
                   1'($urandom_range(0, 1)));
        end

        // Reset asserted while the wordline is up.
        valid = 1'b1;
        wr_i  = 1'b1;
        addr  = 7'd9;
        wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 20 && !rdy_o; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        chk("wl_before_rst", wl_o, 128'd1 << 9);
        #2 nrst = 1'b0;
        #1;
        chk("rst_mid_wl", wl_o, 128'd0);
        chk("rst_mid_ctl", {125'd0, write_o, pch_o, saen_o}, 128'd0);
        chk("rst_mid_ready", 128'(rdy_o), 128'd0);
        chk("rst_mid_rd_data", 128'(rdd_o), 128'd0);
        rd_m[0] = '0;
        rd_m[1] = '0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_ready", 128'(rdy_o), 128'd1);
        chk("post_rst_idle", {wl_o[124:0], pch_o, saen_o, write_o}, 128'd0);

        // Stretched phases with 100 rows, including out-of-range rows.
        sel = 1'b1;
        @(negedge clk);
        run_op(1'b0, 7'($urandom_range(0, 99)), 32'h0, 1'b0);
        run_op(1'b0, 7'd110, 32'h0, 1'b0);
        run_op(1'b1, 7'd120, $urandom, 1'b0);
        run_op(1'b0, 7'($urandom_range(0, 99)), 32'h0, 1'b1);
        run_op(1'b1, 7'($urandom_range(0, 99)), $urandom, 1'b0);
        run_op(1'b0, 7'($urandom_range(0, 127)), 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
